alu_issue_queue: RTL and testbench

Command queue and two-stage issue pipeline placed directly upstream of the 16-bit combinational ALU. It buffers ALU commands from the decode side with a valid/ready handshake and presents one command at a time on registered ALU operand ports. It captures the ALU's combinational result and carry into an output register and returns them downstream with a second valid/ready handshake. An on-chip FIFO absorbs bursts; a flush input discards all in-flight work.

---
 rtl/alu_issue_queue_if.sv | 41 ++++
 rtl/alu_issue_queue.sv | 120 ++++++++++++
 tb/tb_alu_issue_queue.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_queue_if.sv
// Bundle of decode, ALU and result-side signals for alu_issue_queue.
// slave is the queue's view; master is the surrounding decode/ALU/sink view.
interface alu_issue_queue_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  logic                         flush;
  logic                         in_valid;
  logic                         in_ready;
  logic [3:0]                   in_opcode;
  logic [WIDTH-1:0]             in_a;
  logic [WIDTH-1:0]             in_b;
  logic [4:0]                   in_shift;
  logic [3:0]                   alu_opcode;
  logic [WIDTH-1:0]             alu_input1;
  logic [WIDTH-1:0]             alu_input2;
  logic [4:0]                   alu_shiftValue;
  logic [WIDTH-1:0]             alu_result;
  logic                         alu_carry;
  logic                         out_valid;
  logic                         out_ready;
  logic [WIDTH-1:0]             out_result;
  logic                         out_carry;
  logic [3:0]                   out_opcode;
  logic                         out_illegal;
  logic [$clog2(DEPTH+1)-1:0]   level;

  modport slave (
    input  flush, in_valid, in_opcode, in_a, in_b, in_shift,
           alu_result, alu_carry, out_ready,
    output in_ready, alu_opcode, alu_input1, alu_input2, alu_shiftValue,
           out_valid, out_result, out_carry, out_opcode, out_illegal, level
  );

  modport master (
    output flush, in_valid, in_opcode, in_a, in_b, in_shift,
           alu_result, alu_carry, out_ready,
    input  in_ready, alu_opcode, alu_input1, alu_input2, alu_shiftValue,
           out_valid, out_result, out_carry, out_opcode, out_illegal, level
  );
endinterface

// File: rtl/alu_issue_queue.sv
// Command FIFO plus two-stage issue pipeline (S1 drives the ALU, S2 holds its
// result) in front of a 16-bit combinational ALU.
module alu_issue_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  alu_issue_queue_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [3:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       shift;
  } cmd_t;

  cmd_t             mem [DEPTH];
  cmd_t             head;
  cmd_t             s1;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    level;
  logic             s1_valid;
  logic             out_valid;
  logic [WIDTH-1:0] out_result;
  logic             out_carry;
  logic [3:0]       out_opcode;
  logic             out_illegal;
  logic             not_full;
  logic             push;
  logic             pop;
  logic             s2_take;
  logic             s1_adv;

  // rst_n only gates the visible ready; internal enables use not_full since
  // the flops are held in reset anyway.
  assign not_full = (level < LW'(DEPTH));
  assign s2_take  = !out_valid || bus.out_ready;
  assign s1_adv   = s1_valid && s2_take && !bus.flush;
  assign push     = bus.in_valid && not_full && !bus.flush;
  assign pop      = (level != '0) && (!s1_valid || s2_take) && !bus.flush;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{opcode: bus.in_opcode, a: bus.in_a, b: bus.in_b, shift: bus.in_shift};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // S1: ALU operand registers hold their last value while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (bus.flush) begin
      s1_valid <= 1'b0;
    end else if (pop) begin
      s1_valid <= 1'b1;
      s1       <= head;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_carry   <= 1'b0;
      out_opcode  <= '0;
      out_illegal <= 1'b0;
    end else if (bus.flush) begin
      out_valid <= 1'b0;
    end else if (s1_adv) begin
      out_valid   <= 1'b1;
      out_result  <= bus.alu_result;
      out_carry   <= bus.alu_carry;
      out_opcode  <= s1.opcode;
      out_illegal <= (s1.opcode > 4'd9);
    end else if (bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.in_ready       = rst_n && not_full;
  assign bus.level          = level;
  assign bus.alu_opcode     = s1.opcode;
  assign bus.alu_input1     = s1.a;
  assign bus.alu_input2     = s1.b;
  assign bus.alu_shiftValue = s1.shift;
  assign bus.out_valid      = out_valid;
  assign bus.out_result     = out_result;
  assign bus.out_carry      = out_carry;
  assign bus.out_opcode     = out_opcode;
  assign bus.out_illegal    = out_illegal;
endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a behavioural 16-bit ALU attached.
module tb_alu_issue_queue;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [16:0] diff;

  alu_issue_queue_if #(.WIDTH(16), .DEPTH(4)) bus ();

  alu_issue_queue #(.WIDTH(16), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Opcodes: 0 ROL, 1 ROR, 2 MAX, 3 MIN, 4 SUB (carry = borrow), 5 SEQ,
  // 6 SRA, 7 OR, 8 SNE, 9 SLL, others 0.
  always_comb begin
    diff = {1'b0, bus.alu_input1} - {1'b0, bus.alu_input2};
    bus.alu_result = '0;
    bus.alu_carry  = 1'b0;
    case (bus.alu_opcode)
      4'd0: bus.alu_result = (bus.alu_input1 << bus.alu_shiftValue[3:0]) |
                             (bus.alu_input1 >> (5'd16 - {1'b0, bus.alu_shiftValue[3:0]}));
      4'd1: bus.alu_result = (bus.alu_input1 >> bus.alu_shiftValue[3:0]) |
                             (bus.alu_input1 << (5'd16 - {1'b0, bus.alu_shiftValue[3:0]}));
      4'd2: bus.alu_result = (bus.alu_input1 > bus.alu_input2) ? bus.alu_input1 : bus.alu_input2;
      4'd3: bus.alu_result = (bus.alu_input1 < bus.alu_input2) ? bus.alu_input1 : bus.alu_input2;
      4'd4: begin
        bus.alu_result = diff[15:0];
        bus.alu_carry  = diff[16];
      end
      4'd5: bus.alu_result = {15'd0, bus.alu_input1 == bus.alu_input2};
      4'd6: bus.alu_result = $signed(bus.alu_input1) >>> bus.alu_shiftValue;
      4'd7: bus.alu_result = bus.alu_input1 | bus.alu_input2;
      4'd8: bus.alu_result = {15'd0, bus.alu_input1 != bus.alu_input2};
      4'd9: bus.alu_result = bus.alu_input1 << bus.alu_shiftValue;
      default: bus.alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [4:0] sh);
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_shift  = sh;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_opcode = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_shift  = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #3;
    check("rst_in_ready",  32'(bus.in_ready), 32'h0);
    check("rst_level",     32'(bus.level), 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_alu_op",    32'(bus.alu_opcode), 32'h0);
    check("rst_out_res",   32'(bus.out_result), 32'h0);
    #19 rst_n = 1'b1;
    #1;
    check("rel_in_ready",  32'(bus.in_ready), 32'h1);
    tick();

    // Single OR, 2-clock latency
    bus.out_ready = 1'b1;
    drive(4'd7, 16'h00F0, 16'h0F00, 5'd0);
    check("or_in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    bus.in_valid = 1'b0;
    check("or_e0_valid", 32'(bus.out_valid), 32'h0);
    check("or_e0_level", 32'(bus.level), 32'h1);
    tick();
    check("or_e1_valid", 32'(bus.out_valid), 32'h0);
    check("or_e1_aluop", 32'(bus.alu_opcode), 32'h7);
    check("or_e1_in1",   32'(bus.alu_input1), 32'h00F0);
    tick();
    check("or_e2_valid", 32'(bus.out_valid), 32'h1);
    check("or_result",   32'(bus.out_result), 32'h0FF0);
    check("or_opcode",   32'(bus.out_opcode), 32'h7);
    check("or_illegal",  32'(bus.out_illegal), 32'h0);
    check("or_level",    32'(bus.level), 32'h0);
    tick();
    check("or_drained",  32'(bus.out_valid), 32'h0);
    check("or_alu_hold", 32'(bus.alu_opcode), 32'h7);

    // Back-to-back stream
    drive(4'd4, 16'h0005, 16'h0003, 5'd0);
    tick();
    drive(4'd2, 16'h1234, 16'h0042, 5'd0);
    tick();
    drive(4'd0, 16'h8001, 16'h0000, 5'd1);
    tick();
    bus.in_valid = 1'b0;
    check("bb_sub_valid", 32'(bus.out_valid), 32'h1);
    check("bb_sub_res",   32'(bus.out_result), 32'h0002);
    check("bb_sub_op",    32'(bus.out_opcode), 32'h4);
    check("bb_sub_carry", 32'(bus.out_carry), 32'h0);
    check("bb_level",     32'(bus.level), 32'h1);
    tick();
    check("bb_max_valid", 32'(bus.out_valid), 32'h1);
    check("bb_max_res",   32'(bus.out_result), 32'h1234);
    check("bb_max_op",    32'(bus.out_opcode), 32'h2);
    tick();
    check("bb_rol_valid", 32'(bus.out_valid), 32'h1);
    check("bb_rol_res",   32'(bus.out_result), 32'h0003);
    check("bb_rol_op",    32'(bus.out_opcode), 32'h0);
    tick();
    check("bb_end_valid", 32'(bus.out_valid), 32'h0);

    // Illegal opcode between two legal ones
    drive(4'd4, 16'h0003, 16'h0005, 5'd0);
    tick();
    drive(4'd12, 16'hFFFF, 16'hFFFF, 5'd3);
    tick();
    drive(4'd7, 16'h0001, 16'h0002, 5'd0);
    tick();
    bus.in_valid = 1'b0;
    check("il_sub_res",   32'(bus.out_result), 32'hFFFE);
    check("il_sub_carry", 32'(bus.out_carry), 32'h1);
    check("il_sub_ill",   32'(bus.out_illegal), 32'h0);
    tick();
    check("il_bad_valid", 32'(bus.out_valid), 32'h1);
    check("il_bad_res",   32'(bus.out_result), 32'h0000);
    check("il_bad_ill",   32'(bus.out_illegal), 32'h1);
    check("il_bad_op",    32'(bus.out_opcode), 32'hC);
    check("il_bad_carry", 32'(bus.out_carry), 32'h0);
    tick();
    check("il_or_res",    32'(bus.out_result), 32'h0003);
    check("il_or_ill",    32'(bus.out_illegal), 32'h0);
    tick();

    // Backpressure: six accepts fill S2, S1 and the FIFO
    bus.out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(4'd7, 16'(i), 16'h0100, 5'd0);
      check($sformatf("bp_in_ready_%0d", i), 32'(bus.in_ready), (i < 6) ? 32'h1 : 32'h0);
      tick();
    end
    bus.in_valid = 1'b0;
    check("bp_level",    32'(bus.level), 32'h4);
    check("bp_in_ready", 32'(bus.in_ready), 32'h0);
    check("bp_valid",    32'(bus.out_valid), 32'h1);
    for (int k = 0; k < 2; k++) begin
      check("bp_hold_res", 32'(bus.out_result), 32'h0100);
      check("bp_hold_op",  32'(bus.out_opcode), 32'h7);
      check("bp_hold_lvl", 32'(bus.level), 32'h4);
      tick();
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("bp_drain_valid_%0d", k), 32'(bus.out_valid), 32'h1);
      check($sformatf("bp_drain_res_%0d", k), 32'(bus.out_result), 32'h0100 | 32'(k));
      if (k == 1) begin
        check("bp_rel_level", 32'(bus.level), 32'h3);
        check("bp_rel_ready", 32'(bus.in_ready), 32'h1);
      end
      tick();
    end
    check("bp_end_valid", 32'(bus.out_valid), 32'h0);
    check("bp_end_level", 32'(bus.level), 32'h0);

    // Flush with S2, S1 and three FIFO entries plus a concurrent push
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(4'd7, 16'h0010 + 16'(i), 16'h0000, 5'd0);
      tick();
    end
    check("fl_pre_level", 32'(bus.level), 32'h3);
    check("fl_pre_valid", 32'(bus.out_valid), 32'h1);
    drive(4'd7, 16'hDEAD, 16'h0000, 5'd0);
    bus.flush = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("fl_valid",    32'(bus.out_valid), 32'h0);
    check("fl_level",    32'(bus.level), 32'h0);
    check("fl_in_ready", 32'(bus.in_ready), 32'h1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("fl_quiet_%0d", k), 32'(bus.out_valid), 32'h0);
    end

    // Asynchronous reset during a stall
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(4'd7, 16'h00F0, 16'h0F00, 5'd0);
      tick();
    end
    bus.in_valid = 1'b0;
    check("ar_pre_valid", 32'(bus.out_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid",    32'(bus.out_valid), 32'h0);
    check("ar_result",   32'(bus.out_result), 32'h0);
    check("ar_opcode",   32'(bus.out_opcode), 32'h0);
    check("ar_level",    32'(bus.level), 32'h0);
    check("ar_in_ready", 32'(bus.in_ready), 32'h0);
    check("ar_alu_op",   32'(bus.alu_opcode), 32'h0);
    check("ar_alu_in1",  32'(bus.alu_input1), 32'h0);
    #2 rst_n = 1'b1;
    tick();
    bus.out_ready = 1'b1;
    drive(4'd9, 16'h0001, 16'h0000, 5'd4);
    check("ar_new_ready", 32'(bus.in_ready), 32'h1);
    tick();
    bus.in_valid = 1'b0;
    check("ar_new_e0", 32'(bus.out_valid), 32'h0);
    tick();
    check("ar_new_e1", 32'(bus.out_valid), 32'h0);
    tick();
    check("ar_new_e2",  32'(bus.out_valid), 32'h1);
    check("ar_new_res", 32'(bus.out_result), 32'h0010);
    check("ar_new_op",  32'(bus.out_opcode), 32'h9);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
